ls_unit: RTL and testbench
==========================

LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request queue entries (power of 2).
REQ-002 SHALL have parameter TAG_WIDTH, default 4, completion tag width.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream offers an access this cycle.
REQ-006 in_ready  out  1  queue can accept; equals (count < FIFO_DEPTH), combinational from count.
REQ-007 in_we  in  1  1 = store, 0 = load.
REQ-008 in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-009 in_addr  in  32  byte address.
REQ-010 in_data  in  32  store data, right-aligned.
REQ-011 in_tag  in  TAG_WIDTH  tag returned with completion.
REQ-012 flush  in  1  discard queued and in-flight completions.
REQ-013 ls_valid  out  1  request to memory controller, registered.
REQ-014 ls_we / ls_addr / ls_src  out  1/32/32  write enable, word address (in_addr>>2), write data; registered.
REQ-015 ls_done / ls_data  in  1/32  controller completion pulse and read word.
REQ-016 out_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-017 out_tag / out_data / out_err  out  TAG_WIDTH/32/1  completion tag, formatted load result (0 for stores), error flag.

Function
REQ-018 Queue SHALL be a circular FIFO with wrapping rd/wr pointers and count; push on in_valid&&in_ready; push and pop in same cycle leave count unchanged; in_valid while full is ignored.
REQ-019 FSM states SHALL be IDLE, REQ, WAIT; head popped only in IDLE with count>0.
REQ-020 Error on pop: H with addr[0]=1, W with addr[1:0]!=0, or illegal funct3 (011, 11x, or store with 1xx): no memory access; next cycle out_valid=1, out_err=1, out_data=0; stay IDLE.
REQ-021 Legal pop: next cycle ls_valid=1 with ls_addr=addr>>2, ls_we=1 only for SW (ls_src=in_data), else ls_we=0; state REQ.
REQ-022 ls_valid SHALL be high exactly one cycle per request (REQ deasserts it, goes WAIT); ls_addr/ls_we/ls_src held stable until next request.
REQ-023 In WAIT, ls_done for a load: out_data = byte lane addr[1:0] (B sign-extended, BU zero-extended), half lane addr[1] (H/HU likewise), or full word; out_valid next cycle; IDLE.
REQ-024 SB/SH SHALL be read-modify-write: first ls_done returns word; replace byte lane addr[1:0] with data[7:0] or half lane addr[1] with data[15:0]; next cycle ls_valid=1, ls_we=1, ls_src=merged word; REQ; second ls_done completes.
REQ-025 Store completion: out_valid=1, out_data=0, out_err=0.
REQ-026 Latency from head-popped cycle (t0) to out_valid: loads and SW t0+4; SB/SH t0+7; error t0+1; next pop allowed in the cycle out_valid is high.
REQ-027 New ls_valid SHALL never be raised before the ls_done of the previous request has been observed.
REQ-028 flush SHALL empty FIFO (count=0, pointers equal), drop a same-cycle push, and suppress out_valid for the in-flight op; the in-flight memory access (including an RMW write phase) completes to memory, then FSM returns to IDLE.
REQ-029 flush coinciding with a completion cycle SHALL suppress that out_valid.

Reset
REQ-030 On rst: state IDLE, count=0, pointers 0, ls_valid=0, ls_we=0, ls_addr=0, ls_src=0, out_valid=0, out_err=0, out_data=0, out_tag=0.
REQ-031 rst mid-operation SHALL abandon any transaction (controller reset by same rst); no out_valid until new push.

Verification
REQ-032 LW addr 0x100, mem[0x40]=0xDEADBEEF, tag 3 -> ls_valid at t0+1, ls_addr 0x40, out_valid t0+4, out_data 0xDEADBEEF, tag 3.
REQ-033 LB addr 0x103 then LBU addr 0x103, word 0x80FF_0000 -> out_data 0xFFFFFF80 then 0x00000080.
REQ-034 SB addr 0x201 data 0xAB, mem[0x80]=0x11223344 -> read then write 0x1122AB44, out_valid t0+7, out_data 0.
REQ-035 LW addr 0x102 -> no ls_valid, out_valid t0+1 with out_err=1.
REQ-036 Push 5 back-to-back with controller busy -> in_ready low after 4; completions in push order, tags intact across pointer wrap.
REQ-037 flush during WAIT of SH with 2 queued -> RMW write still issued, no out_valid, count 0, IDLE afterward.

Source files
------------

// File: rtl/ls_unit.sv
// ls_unit: in-order load/store front end. Requests are queued, issued one at a
// time to a word-addressed memory controller, and retired with a tagged
// completion pulse. Byte and half stores are done as read-modify-write.
module ls_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_we,
  input  logic [2:0]           in_funct3,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 ls_valid,
  output logic                 ls_we,
  output logic [31:0]          ls_addr,
  output logic [31:0]          ls_src,
  input  logic                 ls_done,
  input  logic [31:0]          ls_data,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [31:0]          out_data,
  output logic                 out_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                 we;
    logic [2:0]           f3;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  req_t          r_q [FIFO_DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  state_t        r_state, w_nstate;
  req_t          r_cur;
  logic          r_wr_phase;   // RMW store has moved on to its write access
  logic          r_flushed;    // in-flight op was flushed; retire silently

  req_t                 w_head;
  logic                 w_push, w_pop, w_rmw_rd;
  logic                 w_issue, w_iss_we;
  logic [31:0]          w_iss_addr, w_iss_src;
  logic                 w_fin, w_fin_err;
  logic [31:0]          w_fin_data;
  logic [TAG_WIDTH-1:0] w_fin_tag;

  // Illegal width/direction combination or misaligned access
  function automatic logic f_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  f_bad = 1'b0;
      3'b001:  f_bad = a[0];
      3'b010:  f_bad = (a != 2'b00);
      3'b100:  f_bad = we;
      3'b101:  f_bad = we | a[0];
      default: f_bad = 1'b1;
    endcase
  endfunction

  // Extract and extend the addressed lane of a read word
  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  f_load = {{24{b[7]}}, b};
      3'b100:  f_load = {24'd0, b};
      3'b001:  f_load = {{16{h[15]}}, h};
      3'b101:  f_load = {16'd0, h};
      default: f_load = w;
    endcase
  endfunction

  // Insert the store byte/half into the word read back from memory
  function automatic logic [31:0] f_merge(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w, input logic [31:0] d);
    f_merge = w;
    if (f3 == 3'b000) f_merge[{a, 3'b000} +: 8] = d[7:0];
    else              f_merge[{a[1], 4'b0000} +: 16] = d[15:0];
  endfunction

  assign in_ready = (r_count < CW'(FIFO_DEPTH));
  assign w_head   = r_q[r_rd];
  assign w_push   = in_valid && in_ready && !flush;
  assign w_rmw_rd = r_cur.we && (r_cur.f3 != 3'b010) && !r_wr_phase;

  // Queue storage; only written on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= '{we: in_we, f3: in_funct3, addr: in_addr, data: in_data, tag: in_tag};
  end

  // Queue pointers and occupancy; flush empties the queue outright
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  // Next state, pop/issue decisions and completion values
  always_comb begin
    w_nstate   = r_state;
    w_pop      = 1'b0;
    w_issue    = 1'b0;
    w_iss_we   = 1'b0;
    w_iss_addr = {2'b00, r_cur.addr[31:2]};
    w_iss_src  = r_cur.data;
    w_fin      = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_data = '0;
    w_fin_tag  = r_cur.tag;
    case (r_state)
      IDLE: begin
        if (r_count != '0 && !flush) begin
          w_pop     = 1'b1;
          w_fin_tag = w_head.tag;
          if (f_bad(w_head.we, w_head.f3, w_head.addr[1:0])) begin
            w_fin     = 1'b1;
            w_fin_err = 1'b1;
          end else begin
            w_issue    = 1'b1;
            w_iss_we   = w_head.we && (w_head.f3 == 3'b010);
            w_iss_addr = {2'b00, w_head.addr[31:2]};
            w_iss_src  = w_head.data;
            w_nstate   = REQ;
          end
        end
      end
      REQ: w_nstate = WAIT;
      WAIT: begin
        if (ls_done) begin
          if (w_rmw_rd) begin
            w_issue   = 1'b1;
            w_iss_we  = 1'b1;
            w_iss_src = f_merge(r_cur.f3, r_cur.addr[1:0], ls_data, r_cur.data);
            w_nstate  = REQ;
          end else begin
            w_fin      = 1'b1;
            w_fin_data = r_cur.we ? 32'd0 : f_load(r_cur.f3, r_cur.addr[1:0], ls_data);
            w_nstate   = IDLE;
          end
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Current op, RMW phase and flush-suppression tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur      <= '0;
      r_wr_phase <= 1'b0;
      r_flushed  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur      <= w_head;
        r_wr_phase <= 1'b0;
      end else if (w_issue) begin
        r_wr_phase <= 1'b1;
      end
      if (w_nstate == IDLE) r_flushed <= 1'b0;
      else if (flush)       r_flushed <= 1'b1;
    end
  end

  // Registered memory request and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ls_valid  <= 1'b0;
      ls_we     <= 1'b0;
      ls_addr   <= '0;
      ls_src    <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      ls_valid <= w_issue;
      if (w_issue) begin
        ls_we   <= w_iss_we;
        ls_addr <= w_iss_addr;
        ls_src  <= w_iss_src;
      end
      out_valid <= w_fin && !flush && !r_flushed;
      if (w_fin) begin
        out_tag  <= w_fin_tag;
        out_data <= w_fin_data;
        out_err  <= w_fin_err;
      end
    end
  end

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: scoreboard bench for ls_unit with a behavioural memory
// controller and a sequential reference model of the load/store rules.
module tb_ls_unit;
  logic        clk, rst;
  logic        in_valid, in_ready, in_we;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_tag;
  logic        flush;
  logic        ls_valid, ls_we;
  logic [31:0] ls_addr, ls_src;
  logic        ls_done;
  logic [31:0] ls_data;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_data;
  logic        out_err;

  ls_unit #(.FIFO_DEPTH(4), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag), .flush(flush),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_src(ls_src),
    .ls_done(ls_done), .ls_data(ls_data),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_err(out_err)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
    int          pcyc;
    int          lat;
  } exp_t;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  logic [31:0] cmem [256];   // memory as seen by the controller
  logic [31:0] mmem [256];   // memory as predicted by the reference model
  exp_t        sb [$];
  int          ctl_min = 0, ctl_max = 0, ctl_cnt = 0, ctl_nreq = 0;
  bit          ctl_busy = 0;
  logic [7:0]  ctl_idx;
  logic        ctl_we;
  logic [31:0] ctl_src;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  // Reference: sequential semantics of one access against mmem
  function automatic void ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, output logic err, output logic [31:0] res);
    int sz, idx, ofs;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    sz  = int'(f3[1:0]);
    idx = int'(a[9:2]);
    ofs = int'(a[1:0]);
    err = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]) || ((ofs % (1 << sz)) != 0);
    res = 32'd0;
    if (err) return;
    w = mmem[idx];
    b = w[8*ofs +: 8];
    h = w[16*(ofs/2) +: 16];
    if (!we) begin
      case (sz)
        0:       res = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
        1:       res = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
        default: res = w;
      endcase
    end else begin
      case (sz)
        0:       w[8*ofs +: 8] = d[7:0];
        1:       w[16*(ofs/2) +: 16] = d[15:0];
        default: w = d;
      endcase
      mmem[idx] = w;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // Offer one request, hold until accepted; expected result goes to the scoreboard
  task automatic do_push(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] tag, input bit exp_on, input int lat);
    int guard;
    logic err;
    logic [31:0] res;
    exp_t e;
    guard = 0;
    in_valid = 1; in_we = we; in_funct3 = f3; in_addr = a; in_data = d; in_tag = tag;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: in_ready=0 after %0d cycles, want 1", guard);
    end else begin
      ref_op(we, f3, a, d, err, res);
      if (exp_on) begin
        e.tag = tag; e.data = res; e.err = err; e.pcyc = cyc; e.lat = lat;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || ctl_busy) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d completions outstanding, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory controller: accepts one request, answers after a variable delay
  initial begin
    ls_done = 0; ls_data = 0;
    forever begin
      @(negedge clk);
      ls_done = 0;
      if (rst) begin
        ctl_busy = 0;
      end else if (ctl_busy) begin
        n_cmp++;
        if (ls_valid) begin
          n_bad++;
          $display("FAIL ls_overlap: ls_valid=1 before previous ls_done, want 0 (cyc %0d)", cyc);
        end
        if (ctl_cnt == 0) begin
          ls_done = 1;
          ls_data = cmem[ctl_idx];
          if (ctl_we) cmem[ctl_idx] = ctl_src;
          ctl_busy = 0;
        end else begin
          ctl_cnt--;
        end
      end else if (ls_valid) begin
        ctl_busy = 1;
        ctl_nreq++;
        ctl_idx = ls_addr[7:0];
        ctl_we  = ls_we;
        ctl_src = ls_src;
        ctl_cnt = 1 + int'($urandom_range(ctl_max, ctl_min));
      end
    end
  end

  // Completion monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: out_valid=1 tag=%0d, want no completion", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_tag !== e.tag || out_data !== e.data || out_err !== e.err) begin
            n_bad++;
            $display("FAIL out_resp: got tag=%0d data=0x%08h err=%0b want tag=%0d data=0x%08h err=%0b",
                     out_tag, out_data, out_err, e.tag, e.data, e.err);
          end
          if (e.lat > 0) begin
            n_cmp++;
            if (cyc - e.pcyc != e.lat + 1) begin
              n_bad++;
              $display("FAIL out_latency: got t0+%0d want t0+%0d", cyc - e.pcyc - 1, e.lat);
            end
          end
        end
      end
    end
  end

  // Main stimulus
  initial begin
    int c, nreq0, bad_i;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] ra;
    rst = 1; in_valid = 0; in_we = 0; in_funct3 = 0; in_addr = 0; in_data = 0; in_tag = 0; flush = 0;
    for (int i = 0; i < 256; i++) begin
      cmem[i] = $urandom;
      mmem[i] = cmem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_ls_valid",  32'(ls_valid),  32'd0);
    chk("rst_ls_we",     32'(ls_we),     32'd0);
    chk("rst_ls_addr",   ls_addr,        32'd0);
    chk("rst_ls_src",    ls_src,         32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    rst = 0;
    @(negedge clk);

    // LW aligned: request timing and full-word result
    cmem[8'h40] = 32'hDEADBEEF; mmem[8'h40] = 32'hDEADBEEF;
    do_push(1'b0, 3'b010, 32'h100, 32'h0, 4'd3, 1'b1, 4);
    @(negedge clk);
    chk("lw_ls_valid", 32'(ls_valid), 32'd1);
    chk("lw_ls_addr",  ls_addr,       32'h40);
    chk("lw_ls_we",    32'(ls_we),    32'd0);
    @(negedge clk);
    chk("lw_ls_pulse", 32'(ls_valid), 32'd0);
    wait_drain();

    // LB then LBU on the top byte lane
    cmem[8'h40] = 32'h80FF0000; mmem[8'h40] = 32'h80FF0000;
    do_push(1'b0, 3'b000, 32'h103, 32'h0, 4'd4, 1'b1, 4);
    do_push(1'b0, 3'b100, 32'h103, 32'h0, 4'd5, 1'b1, 0);
    wait_drain();

    // SB read-modify-write
    cmem[8'h80] = 32'h11223344; mmem[8'h80] = 32'h11223344;
    nreq0 = ctl_nreq;
    do_push(1'b1, 3'b000, 32'h201, 32'h000000AB, 4'd6, 1'b1, 7);
    wait_drain();
    chk("sb_mem",      cmem[8'h80],             32'h1122AB44);
    chk("sb_accesses", 32'(ctl_nreq - nreq0),   32'd2);

    // Misaligned LW: error, no memory access
    nreq0 = ctl_nreq;
    do_push(1'b0, 3'b010, 32'h102, 32'h0, 4'd7, 1'b1, 1);
    wait_drain();
    chk("err_accesses", 32'(ctl_nreq - nreq0), 32'd0);

    // Five back-to-back pushes against a slow controller
    ctl_min = 4; ctl_max = 6;
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    do_push(1'b1, 3'b010, 32'h300, 32'hA5A55A5A, 4'd8, 1'b1, 0);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    do_push(1'b0, 3'b010, 32'h300, 32'h0, 4'd9, 1'b1, 0);
    chk("b2b_ready2", 32'(in_ready), 32'd1);
    do_push(1'b0, 3'b001, 32'h302, 32'h0, 4'd10, 1'b1, 0);
    chk("b2b_ready3", 32'(in_ready), 32'd1);
    do_push(1'b0, 3'b100, 32'h301, 32'h0, 4'd11, 1'b1, 0);
    chk("b2b_ready4", 32'(in_ready), 32'd1);
    do_push(1'b1, 3'b010, 32'h304, 32'h01234567, 4'd12, 1'b1, 0);
    chk("b2b_full", 32'(in_ready), 32'd0);
    wait_drain();

    // Flush while an SH is waiting on its read, with two loads queued
    ctl_min = 5; ctl_max = 5;
    nreq0 = ctl_nreq;
    do_push(1'b1, 3'b001, 32'h242, 32'h0000BEEF, 4'd1, 1'b0, 0);
    do_push(1'b0, 3'b010, 32'h100, 32'h0, 4'd13, 1'b0, 0);
    do_push(1'b0, 3'b010, 32'h104, 32'h0, 4'd14, 1'b0, 0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_ready", 32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);
    chk("flush_accesses", 32'(ctl_nreq - nreq0), 32'd2);
    chk("flush_rmw_mem",  cmem[8'h90],           mmem[8'h90]);
    ctl_min = 0; ctl_max = 0;
    do_push(1'b0, 3'b010, 32'h240, 32'h0, 4'd2, 1'b1, 4);
    wait_drain();

    // Random traffic with variable controller latency
    ctl_min = 0; ctl_max = 3;
    for (int i = 0; i < 200; i++) begin
      rwe = ($urandom_range(2, 0) == 0);
      rf3 = 3'($urandom_range(7, 0));
      ra  = 32'($urandom_range(1023, 0));
      if ($urandom_range(3, 0) != 0) ra = ra & ~((32'd1 << rf3[1:0]) - 32'd1);
      do_push(rwe, rf3, ra, $urandom, 4'($urandom), 1'b1, 0);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    wait_drain();

    // Reset in the middle of an access
    ctl_min = 10; ctl_max = 10;
    do_push(1'b0, 3'b010, 32'h10, 32'h0, 4'd9, 1'b1, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rstmid_out_valid", 32'(out_valid), 32'd0);
      chk("rstmid_ls_valid",  32'(ls_valid),  32'd0);
    end
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    ctl_min = 0; ctl_max = 0;
    do_push(1'b0, 3'b010, 32'h10, 32'h0, 4'd10, 1'b1, 4);
    wait_drain();

    // Memory contents written through the DUT against the model
    bad_i = -1;
    for (int i = 0; i < 256; i++)
      if (cmem[i] !== mmem[i] && bad_i < 0) bad_i = i;
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL mem_final: word %0d got 0x%08h want 0x%08h", bad_i, cmem[bad_i], mmem[bad_i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
